// File: rtl/morph_pkg.sv
// Shared definitions for the morphology filter datapath: width helpers and
// the priming policy used by the delay lines.
package morph_pkg;

  // Fill behaviour while a delay line is still priming.
  typedef enum logic {
    FILL_ZERO = 1'b0,  // emit all-zero beats for the first D inputs
    FILL_DROP = 1'b1   // produce no output beat for the first D inputs
  } fill_mode_e;

  // Address width for a memory of 'depth' entries (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/axis_multichannel_z_delay_if.sv
// AXI-Stream beat interface: data, valid and ready for one stream.
interface axis_multichannel_z_delay_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer. An incoming beat passes straight through when the
// buffer is empty and downstream is ready; otherwise it is parked. The
// producer must only offer a beat when there is room (count_o plus any beat
// it already has on the way is below two).
module axis_skid_buffer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [1:0]       count_o
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  // Stored head has priority; an empty buffer forwards the upstream beat.
  assign m_valid_o = (count_q != 2'd0) || s_valid_i;
  assign m_data_o  = (count_q != 2'd0) ? head_q : s_data_i;
  assign count_o   = count_q;

  // Occupancy and slot updates for push, pop, push+pop and flush.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (s_valid_i && !m_ready_i) begin
          head_d  = s_data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (m_ready_i) begin
          if (s_valid_i) head_d = s_data_i;
          else           count_d = 2'd0;
        end else if (s_valid_i) begin
          tail_d  = s_data_i;
          count_d = 2'd2;
        end
      end
      default: begin
        if (m_ready_i) begin
          head_d = tail_q;
          if (s_valid_i) tail_d = s_data_i;
          else           count_d = 2'd1;
        end
      end
    endcase
    if (flush_i) count_d = 2'd0;
  end

  // Occupancy register: the only control state in the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) count_q <= 2'd0;
    else        count_q <= count_d;
  end

  // Data slots; count_q says which of them hold live beats.
  always_ff @(posedge clk) begin
    // NOTE: data storage is deliberately not reset; validity is tracked separately.
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

// File: rtl/axis_multichannel_z_delay.sv
// AXI-Stream z^-D delay line. Every accepted beat is written into a ring
// buffer and the beat accepted D beats earlier is read out of the same slot
// (read-first), then handed to a skid buffer that absorbs output stalls.
// The delay is reloadable at runtime; reloading restarts the line.
module axis_multichannel_z_delay
  import morph_pkg::*;
#(
  parameter int         DATA_WIDTH    = 16,
  parameter int         CHANNELS      = 1,
  parameter int         MAX_DELAY     = 128,
  parameter int         DEFAULT_DELAY = 70,
  parameter fill_mode_e FILL_MODE     = FILL_ZERO
) (
  input  logic                        clk,
  input  logic                        areset_n,
  input  logic [cnt_w(MAX_DELAY)-1:0] cfg_delay,
  input  logic                        cfg_load,
  output logic                        primed,
  axis_multichannel_z_delay_if.slave  axis_in,
  axis_multichannel_z_delay_if.master axis_out
);

  localparam int W  = CHANNELS * DATA_WIDTH;
  localparam int DW = cnt_w(MAX_DELAY);
  localparam int AW = addr_w(MAX_DELAY);

  // Map a requested delay onto the supported range 1..MAX_DELAY.
  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] v);
    if (v == '0)               return DW'(1);
    if (v > DW'(MAX_DELAY))    return DW'(MAX_DELAY);
    return v;
  endfunction

  logic [DW-1:0] d_q;          // active delay D
  logic [DW-1:0] fill_q;       // accepted beats since restart, saturating at D
  logic [AW-1:0] wp_q, wp_d;   // ring pointer, wraps D-1 -> 0
  logic          ready_en_q;   // low until the first clock after reset release
  logic          primed_q;
  logic          rd_valid_q;   // a beat is in the RAM read stage
  logic          rd_zero_q;    // that beat was read while priming
  logic [W-1:0]  ram [MAX_DELAY];
  logic [W-1:0]  ram_rd_q;
  logic [W-1:0]  rd_data;
  logic [1:0]    skid_count;
  logic          in_ready, accept, priming, emit;

  // Room exists only if the skid plus the beat in the read stage leave a slot.
  assign in_ready = ready_en_q && !cfg_load &&
                    ((skid_count + {1'b0, rd_valid_q}) < 2'd2);
  assign accept   = axis_in.tvalid && in_ready;
  assign priming  = (fill_q != d_q);
  assign emit     = accept && (!priming || (FILL_MODE == FILL_ZERO));
  assign wp_d     = (DW'(wp_q) == d_q - 1'b1) ? '0 : wp_q + 1'b1;

  assign axis_in.tready = in_ready;
  assign primed         = primed_q;

  // Line control: delay, pointer, priming count and the read-stage flags.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      d_q        <= DW'(DEFAULT_DELAY);
      wp_q       <= '0;
      fill_q     <= '0;
      primed_q   <= 1'b0;
      ready_en_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (cfg_load) begin
        d_q        <= clamp_delay(cfg_delay);
        wp_q       <= '0;
        fill_q     <= '0;
        primed_q   <= 1'b0;
        rd_valid_q <= 1'b0;
        rd_zero_q  <= 1'b0;
      end else begin
        rd_valid_q <= emit;
        if (accept) begin
          wp_q      <= wp_d;
          rd_zero_q <= priming;
          if (priming) begin
            fill_q   <= fill_q + 1'b1;
            primed_q <= (fill_q + 1'b1 == d_q);
          end
        end
      end
    end
  end

  // Simple dual-port RAM, read-first: the slot yields beat k-D as beat k lands.
  always_ff @(posedge clk) begin
    if (accept) begin
      ram[wp_q] <= axis_in.tdata;
      ram_rd_q  <= ram[wp_q];
    end
  end

  // RAM contents are not trusted until primed, so priming beats read as zero.
  assign rd_data = (rd_valid_q && !rd_zero_q) ? ram_rd_q : '0;

  axis_skid_buffer #(
    .WIDTH (W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (areset_n),
    .flush_i   (cfg_load),
    .s_data_i  (rd_data),
    .s_valid_i (rd_valid_q),
    .m_data_o  (axis_out.tdata),
    .m_valid_o (axis_out.tvalid),
    .m_ready_i (axis_out.tready),
    .count_o   (skid_count)
  );

endmodule

// File: tb/tb_axis_multichannel_z_delay.sv
// Bench for the z^-D delay line: a queue-based reference of "output = input
// accepted D beats ago", checked on every output handshake, plus directed
// scenarios with hand-computed expectations.
module tb_axis_multichannel_z_delay;
  import morph_pkg::*;

  localparam int LW   = 16;
  localparam int CH   = 2;
  localparam int W    = LW * CH;
  localparam int MAXD = 128;
  localparam int DEFD = 70;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic [7:0] cfg_delay = 8'd0;
  logic       cfg_load = 1'b0;
  logic       cfg_load_dd = 1'b0;
  logic       primed_w, primed_dd;

  axis_multichannel_z_delay_if #(.WIDTH(W)) in_if  ();
  axis_multichannel_z_delay_if #(.WIDTH(W)) out_if ();
  axis_multichannel_z_delay_if #(.WIDTH(W)) dd_in  ();
  axis_multichannel_z_delay_if #(.WIDTH(W)) dd_out ();

  axis_multichannel_z_delay #(
    .DATA_WIDTH(LW), .CHANNELS(CH), .MAX_DELAY(MAXD),
    .DEFAULT_DELAY(DEFD), .FILL_MODE(FILL_ZERO)
  ) u_dut (
    .clk(clk), .areset_n(areset_n), .cfg_delay(cfg_delay), .cfg_load(cfg_load),
    .primed(primed_w), .axis_in(in_if), .axis_out(out_if)
  );

  axis_multichannel_z_delay #(
    .DATA_WIDTH(LW), .CHANNELS(CH), .MAX_DELAY(MAXD),
    .DEFAULT_DELAY(DEFD), .FILL_MODE(FILL_DROP)
  ) u_drop (
    .clk(clk), .areset_n(areset_n), .cfg_delay(cfg_delay), .cfg_load(cfg_load_dd),
    .primed(primed_dd), .axis_in(dd_in), .axis_out(dd_out)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat value v: lane 0 carries v, lane 1 carries its complement.
  function automatic logic [W-1:0] mk(input int v);
    logic [LW-1:0] s;
    s = LW'(v);
    return {s ^ 16'hFFFF, s};
  endfunction

  // Output ready: either a fixed level or a fair coin each cycle.
  bit   rand_rdy  = 1'b0;
  logic rdy_level = 1'b1;
  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_level;
    end
  end

  // Reference model: z^-D as a history queue of accepted beats.
  int           model_d = DEFD;
  int           acc_cnt = 0;
  logic [W-1:0] hist[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] out_log[$];
  logic [W-1:0] dd_log[$];
  bit           stall_pending = 1'b0;
  bit           load_prev = 1'b0;
  logic [W-1:0] held;

  always @(negedge clk) begin
    if (!areset_n) begin
      model_d = DEFD; acc_cnt = 0; hist.delete(); exp_q.delete();
      stall_pending = 1'b0; load_prev = 1'b0;
    end else begin
      check("primed", primed_w, acc_cnt >= model_d);
      if (load_prev) check("flush_tvalid", out_if.tvalid, 1'b0);
      if (stall_pending) begin
        check("hold_tvalid", out_if.tvalid, 1'b1);
        check("hold_tdata", out_if.tdata, held);
      end
      if (out_if.tvalid && out_if.tready) begin
        out_log.push_back(out_if.tdata);
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL extra_beat: got %0h expected no beat at %0t", out_if.tdata, $time);
        end else begin
          check("out_tdata", out_if.tdata, exp_q.pop_front());
        end
      end
      stall_pending = out_if.tvalid && !out_if.tready && !cfg_load;
      held          = out_if.tdata;
      load_prev     = cfg_load;
      if (cfg_load) begin
        check("tready_on_load", in_if.tready, 1'b0);
        model_d = (cfg_delay == 8'd0) ? 1 : ((int'(cfg_delay) > MAXD) ? MAXD : int'(cfg_delay));
        acc_cnt = 0; hist.delete(); exp_q.delete();
      end else if (in_if.tvalid && in_if.tready) begin
        acc_cnt++;
        hist.push_back(in_if.tdata);
        if (hist.size() > model_d) exp_q.push_back(hist.pop_front());
        else                       exp_q.push_back('0);
      end
    end
  end

  always @(negedge clk)
    if (areset_n && dd_out.tvalid && dd_out.tready) dd_log.push_back(dd_out.tdata);

  // Offer one beat and return #1 after the edge that accepts it.
  task automatic send(input int v);
    int guard;
    guard = 0;
    in_if.tdata  = mk(v);
    in_if.tvalid = 1'b1;
    @(negedge clk);
    while (!in_if.tready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!in_if.tready) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: got tready 0 expected 1 within 500 cycles for beat %0d", v);
    end
    @(posedge clk); #1;
  endtask

  task automatic load(input int d);
    cfg_delay = 8'(d);
    cfg_load  = 1'b1;
    @(posedge clk); #1;
    cfg_load  = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    in_if.tvalid = 1'b0;
    while ((exp_q.size() != 0 || out_if.tvalid) && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before 900000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_if.tvalid = 1'b0; in_if.tdata = '0;
    dd_in.tvalid = 1'b0; dd_in.tdata = '0;
    dd_out.tready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk); #1;
    check("rst_out_tvalid", out_if.tvalid, 1'b0);
    check("rst_out_tdata", out_if.tdata, '0);
    check("rst_in_tready", in_if.tready, 1'b0);
    check("rst_primed", primed_w, 1'b0);
    #2 areset_n = 1'b1;
    #1 check("tready_before_clk", in_if.tready, 1'b0);
    @(posedge clk); #1;
    check("tready_after_clk", in_if.tready, 1'b1);

    // 1: D=4, zero fill, continuous.
    load(4);
    out_log.delete();
    send(1);
    check("t1_latency_tvalid", out_if.tvalid, 1'b1);
    check("t1_latency_tdata", out_if.tdata, '0);
    send(2); send(3);
    check("t1_primed_after3", primed_w, 1'b0);
    send(4);
    check("t1_primed_after4", primed_w, 1'b1);
    for (int v = 5; v <= 10; v++) send(v);
    drain("t1");
    check("t1_count", out_log.size(), 10);
    for (int i = 0; i < 4; i++) check("t1_zero", out_log[i], '0);
    for (int i = 4; i < 10; i++) check("t1_data", out_log[i], mk(i - 3));

    // 2: D=4, drop fill, on the second instance.
    cfg_delay = 8'd4; cfg_load_dd = 1'b1;
    @(posedge clk); #1;
    cfg_load_dd = 1'b0;
    for (int v = 1; v <= 10; v++) begin
      dd_in.tdata = mk(v); dd_in.tvalid = 1'b1;
      @(negedge clk);
      check("t2_tready", dd_in.tready, 1'b1);
      @(posedge clk); #1;
      if (v == 4) begin
        check("t2_primed", primed_dd, 1'b1);
        check("t2_no_priming_beat", dd_out.tvalid, 1'b0);
        check("t2_log_empty", dd_log.size(), 0);
      end
      if (v == 5) begin
        check("t2_first_tvalid", dd_out.tvalid, 1'b1);
        check("t2_first_tdata", dd_out.tdata, mk(1));
      end
    end
    dd_in.tvalid = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("t2_count", dd_log.size(), 6);
    for (int i = 0; i < 6; i++) check("t2_data", dd_log[i], mk(i + 1));

    // 3: D=3, random input gaps and random output ready.
    load(3);
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        in_if.tvalid = 1'b0;
        @(posedge clk); #1;
      end
      send(1000 + i);
    end
    rand_rdy = 1'b0; rdy_level = 1'b1;
    drain("t3");

    // 4: D clamps to MAX_DELAY, then D clamps to 1.
    load(200);
    out_log.delete();
    for (int i = 0; i < 300; i++) send(5000 + i);
    drain("t4");
    check("t4_count", out_log.size(), 300);
    check("t4_last_zero", out_log[127], '0);
    check("t4_first_data", out_log[128], mk(5000));
    check("t4_last_data", out_log[299], mk(5171));
    load(0);
    out_log.delete();
    send(500); send(501); send(502);
    drain("t4b");
    check("t4b_count", out_log.size(), 3);
    check("t4b_0", out_log[0], '0);
    check("t4b_1", out_log[1], mk(500));
    check("t4b_2", out_log[2], mk(501));

    // 5: reload mid-stream with a stalled output and a pending input beat.
    load(5);
    for (int i = 1; i <= 20; i++) send(100 + i);
    rdy_level = 1'b0;
    send(121); send(122);
    in_if.tdata = mk(123); in_if.tvalid = 1'b1;
    load(2);
    check("t5_primed", primed_w, 1'b0);
    check("t5_flushed", out_if.tvalid, 1'b0);
    out_log.delete();
    rdy_level = 1'b1;
    for (int v = 123; v <= 126; v++) send(v);
    drain("t5");
    check("t5_count", out_log.size(), 4);
    check("t5_0", out_log[0], '0);
    check("t5_1", out_log[1], '0);
    check("t5_2", out_log[2], mk(123));
    check("t5_3", out_log[3], mk(124));

    // 6: asynchronous reset with the output stalled.
    load(10);
    for (int i = 1; i <= 15; i++) send(200 + i);
    rdy_level = 1'b0;
    send(216); send(217);
    in_if.tvalid = 1'b0;
    #2 areset_n = 1'b0;
    #1;
    check("t6_tvalid", out_if.tvalid, 1'b0);
    check("t6_tdata", out_if.tdata, '0);
    check("t6_tready", in_if.tready, 1'b0);
    check("t6_primed", primed_w, 1'b0);
    repeat (2) @(posedge clk);
    #2 areset_n = 1'b1;
    #1 check("t6_tready_before_clk", in_if.tready, 1'b0);
    @(posedge clk); #1;
    check("t6_tready_after_clk", in_if.tready, 1'b1);
    rdy_level = 1'b1;
    out_log.delete();
    for (int i = 0; i < 80; i++) send(300 + i);
    drain("t6");
    check("t6_count", out_log.size(), 80);
    check("t6_zero_first", out_log[0], '0);
    check("t6_zero_last", out_log[69], '0);
    check("t6_data_first", out_log[70], mk(300));
    check("t6_data_last", out_log[79], mk(309));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
